// File: rtl/cam_dvp_capture.sv
// DVP camera capture front end.
// Stages the camera pins once on pclk, skips a configurable number of start-up
// frames, packs bytes into 8- or 16-bit pixels, crops to a window and emits
// pixels with SOF/EOL flags, a frame counter and a sticky line-length error.
//
// Output handshake: pix_valid is a one-cycle qualifier with no back-pressure;
// pix_data, sof and eol are meaningful only while pix_valid=1, and pix_data
// holds its last value otherwise.
module cam_dvp_capture #(
    parameter int IN_W        = 1024,
    parameter int IN_H        = 768,
    parameter int WIN_X0      = 0,
    parameter int WIN_Y0      = 0,
    parameter int WIN_W       = 1024,
    parameter int WIN_H       = 768,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    input  logic        byte_mode,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        sof,
    output logic        eol,
    output logic [7:0]  frame_cnt,
    output logic        line_err,
    output logic        capturing
);

    // x needs headroom above IN_W so an over-long line is still distinguishable
    // from a correct one; it saturates instead of wrapping.
    localparam int X_W  = $clog2(IN_W + 2);
    localparam int Y_W  = $clog2(IN_H + 1);
    localparam int SK_W = $clog2(SKIP_FRAMES + 2);

    localparam logic [X_W-1:0]  X_LEN   = X_W'(IN_W);
    localparam logic [X_W-1:0]  WX0     = X_W'(WIN_X0);
    localparam logic [X_W-1:0]  WXW     = X_W'(WIN_W);
    localparam logic [X_W-1:0]  WX_LAST = X_W'(WIN_X0 + WIN_W - 1);
    localparam logic [X_W-1:0]  X_ONE   = X_W'(1);
    localparam logic [Y_W-1:0]  Y_LEN   = Y_W'(IN_H);
    localparam logic [Y_W-1:0]  WY0     = Y_W'(WIN_Y0);
    localparam logic [Y_W-1:0]  WYH     = Y_W'(WIN_H);
    localparam logic [Y_W-1:0]  Y_ONE   = Y_W'(1);
    localparam logic [SK_W-1:0] SK_LOAD = SK_W'(SKIP_FRAMES);
    localparam logic [SK_W-1:0] SK_ONE  = SK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_SKIP    = 2'd2,
        ST_ACTIVE  = 2'd3
    } state_t;

    state_t          state;
    logic [SK_W-1:0] skip_cnt;
    logic            mode8;      // byte_mode latched at frame start
    logic            phase;      // 1 = high byte of a 16-bit pixel is pending
    logic [7:0]      hi_byte;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;

    // Pin staging: stage 1 feeds the datapath, stage 2 only exists for edges.
    logic       vs1, hr1, vs2, hr2;
    logic [7:0] d1;

    // Register camera pins once, then once more for edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs1 <= 1'b0;
            hr1 <= 1'b0;
            d1  <= 8'h00;
            vs2 <= 1'b0;
            hr2 <= 1'b0;
        end else begin
            vs1 <= vsync;
            hr1 <= href;
            d1  <= din;
            vs2 <= vs1;
            hr2 <= hr1;
        end
    end

    logic            vs_rise;
    logic            hr_rise;
    logic            line_end;
    logic            byte_ok;
    logic            cur_phase;
    logic [X_W-1:0]  cur_x;
    logic [X_W-1:0]  next_x;
    logic            pix_done;
    logic [15:0]     pix_word;
    logic [X_W-1:0]  x_off;
    logic [Y_W-1:0]  y_off;
    logic            in_win;
    logic            len_bad;

    // Edge detection, byte packing and window decode for the current byte.
    always_comb begin
        vs_rise   = vs1 & ~vs2;
        hr_rise   = hr1 & ~hr2;
        // A line only counts if it was open while vsync was low; a line end
        // coinciding with a vsync rise still counts.
        line_end  = ~hr1 & hr2 & ~vs2;
        byte_ok   = (state == ST_ACTIVE) & hr1 & ~vs1;
        cur_phase = hr_rise ? 1'b0 : phase;
        cur_x     = hr_rise ? '0 : x;
        next_x    = (cur_x == '1) ? cur_x : cur_x + X_ONE;
        pix_done  = byte_ok & (mode8 | cur_phase);
        pix_word  = mode8 ? {8'h00, d1} : {hi_byte, d1};
        // Unsigned offset trick: a position left of/above the window wraps to
        // a large value, so one compare per axis covers both bounds.
        x_off     = cur_x - WX0;
        y_off     = y - WY0;
        in_win    = (x_off < WXW) & (y_off < WYH);
        len_bad   = (x != X_LEN) | (~mode8 & phase) | (y == Y_LEN);
    end

    // Capture FSM with its counters and registered pixel outputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            mode8     <= 1'b0;
            phase     <= 1'b0;
            hi_byte   <= 8'h00;
            x         <= '0;
            y         <= '0;
            pix_valid <= 1'b0;
            pix_data  <= 16'h0000;
            sof       <= 1'b0;
            eol       <= 1'b0;
            frame_cnt <= 8'h00;
            line_err  <= 1'b0;
            capturing <= 1'b0;
        end else if (!en) begin
            // Disable aborts everything except the frame counter.
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            phase     <= 1'b0;
            x         <= '0;
            y         <= '0;
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            line_err  <= 1'b0;
            capturing <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_WAIT_VS;
                end

                ST_WAIT_VS: begin
                    if (vs_rise) begin
                        skip_cnt <= SK_LOAD;
                        mode8    <= byte_mode;
                        x        <= '0;
                        y        <= '0;
                        phase    <= 1'b0;
                        if (SKIP_FRAMES == 0) begin
                            state     <= ST_ACTIVE;
                            capturing <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                        end else begin
                            state <= ST_SKIP;
                        end
                    end
                end

                ST_SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt <= SK_ONE) begin
                            skip_cnt  <= '0;
                            state     <= ST_ACTIVE;
                            capturing <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                            mode8     <= byte_mode;
                            x         <= '0;
                            y         <= '0;
                            phase     <= 1'b0;
                        end else begin
                            skip_cnt <= skip_cnt - SK_ONE;
                        end
                    end
                end

                ST_ACTIVE: begin
                    // Byte packing and pixel position.
                    if (byte_ok) begin
                        if (!mode8 && !cur_phase) begin
                            hi_byte <= d1;
                        end
                        phase <= mode8 ? 1'b0 : ~cur_phase;
                    end else if (hr_rise) begin
                        phase <= 1'b0;
                    end

                    if (pix_done) begin
                        x <= next_x;
                    end else if (hr_rise) begin
                        x <= '0;
                    end

                    if (pix_done && in_win) begin
                        pix_valid <= 1'b1;
                        pix_data  <= pix_word;
                        sof       <= (cur_x == WX0) && (y == WY0);
                        eol       <= (cur_x == WX_LAST);
                    end

                    // Line end is evaluated before any frame clear below.
                    if (line_end) begin
                        if (len_bad) begin
                            line_err <= 1'b1;
                        end
                        if (y != Y_LEN) begin
                            y <= y + Y_ONE;
                        end
                    end

                    if (vs_rise) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        mode8     <= byte_mode;
                        x         <= '0;
                        y         <= '0;
                        phase     <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture with an 8x4 input, 4x2 window at (2,1).
// dut_a skips 2 frames; dut_b skips none and is used for the counter wrap and
// the coincident line-end / frame-start case.
module tb_cam_dvp_capture;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en_b;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic        byte_mode;

    logic        pix_valid, sof, eol, line_err, capturing;
    logic [15:0] pix_data;
    logic [7:0]  frame_cnt;
    logic        pix_valid_b, sof_b, eol_b, line_err_b, capturing_b;
    logic [15:0] pix_data_b;
    logic [7:0]  frame_cnt_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mark_cyc = 0;

    logic [15:0] rec_data[$];
    logic        rec_sof[$];
    logic        rec_eol[$];
    int          rec_cyc[$];

    cam_dvp_capture #(
        .IN_W(8), .IN_H(4), .WIN_X0(2), .WIN_Y0(1), .WIN_W(4), .WIN_H(2),
        .SKIP_FRAMES(2)
    ) dut_a (
        .pclk(pclk), .rst_n(rst_n), .en(en), .vsync(vsync), .href(href),
        .din(din), .byte_mode(byte_mode), .pix_valid(pix_valid),
        .pix_data(pix_data), .sof(sof), .eol(eol), .frame_cnt(frame_cnt),
        .line_err(line_err), .capturing(capturing)
    );

    cam_dvp_capture #(
        .IN_W(8), .IN_H(4), .WIN_X0(2), .WIN_Y0(1), .WIN_W(4), .WIN_H(2),
        .SKIP_FRAMES(0)
    ) dut_b (
        .pclk(pclk), .rst_n(rst_n), .en(en_b), .vsync(vsync), .href(href),
        .din(din), .byte_mode(byte_mode), .pix_valid(pix_valid_b),
        .pix_data(pix_data_b), .sof(sof_b), .eol(eol_b), .frame_cnt(frame_cnt_b),
        .line_err(line_err_b), .capturing(capturing_b)
    );

    // Clock and cycle counter.
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Record every pixel dut_a emits, sampled mid-cycle.
    always @(negedge pclk) begin
        if (pix_valid) begin
            rec_data.push_back(pix_data);
            rec_sof.push_back(sof);
            rec_eol.push_back(eol);
            rec_cyc.push_back(cyc);
        end
    end

    task automatic rec_clear();
        rec_data.delete();
        rec_sof.delete();
        rec_eol.delete();
        rec_cyc.delete();
    endtask

    task automatic drive_vsync();
        vsync = 1'b1;
        repeat (2) @(negedge pclk);
        vsync = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    // Line bytes are {line, index}: line 1 carries 0x10, 0x11, ...
    task automatic drive_line(input int line, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            din  = 8'((line << 4) + i);
            if (line == 1 && i == 5) mark_cyc = cyc;
            @(negedge pclk);
        end
        href = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic drive_frame(input int nbytes);
        drive_vsync();
        for (int l = 0; l < 4; l++) drive_line(l, nbytes);
    endtask

    task automatic test_reset();
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid got %0b exp 0", pix_valid); end
        tests++; if (pix_data !== 16'h0000) begin fails++; $display("FAIL reset_pix_data got %h exp 0000", pix_data); end
        tests++; if (sof !== 1'b0 || eol !== 1'b0) begin fails++; $display("FAIL reset_sof_eol got %0b%0b exp 00", sof, eol); end
        tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        tests++; if (line_err !== 1'b0) begin fails++; $display("FAIL reset_line_err got %0b exp 0", line_err); end
        tests++; if (capturing !== 1'b0) begin fails++; $display("FAIL reset_capturing got %0b exp 0", capturing); end
        tests++; if (frame_cnt_b !== 8'd0 || capturing_b !== 1'b0) begin fails++; $display("FAIL reset_b got cnt %0d cap %0b exp 0 0", frame_cnt_b, capturing_b); end
    endtask

    task automatic test_skip();
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3) @(negedge pclk);
        rec_clear();
        drive_frame(16);
        drive_frame(16);
        tests++; if (capturing !== 1'b0) begin fails++; $display("FAIL skip_not_capturing got %0b exp 0", capturing); end
        drive_vsync();
        tests++; if (rec_data.size() != 0) begin fails++; $display("FAIL skip_no_pixels got %0d exp 0", rec_data.size()); end
        tests++; if (capturing !== 1'b1) begin fails++; $display("FAIL skip_capturing got %0b exp 1", capturing); end
        tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL skip_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_pack16();
        logic [15:0] exp_w [4];
        exp_w = '{16'h1415, 16'h1617, 16'h1819, 16'h1A1B};
        rec_clear();
        for (int l = 0; l < 4; l++) drive_line(l, 16);
        tests++; if (rec_data.size() != 8) begin fails++; $display("FAIL p16_count got %0d exp 8", rec_data.size()); end
        if (rec_data.size() == 8) begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (rec_data[i] !== exp_w[i]) begin fails++; $display("FAIL p16_data%0d got %h exp %h", i, rec_data[i], exp_w[i]); end
            end
            tests++; if (rec_data[4] !== 16'h2425) begin fails++; $display("FAIL p16_line2 got %h exp 2425", rec_data[4]); end
            tests++; if (rec_sof[0] !== 1'b1 || rec_sof[1] !== 1'b0 || rec_sof[4] !== 1'b0) begin fails++; $display("FAIL p16_sof got %0b%0b%0b exp 100", rec_sof[0], rec_sof[1], rec_sof[4]); end
            tests++; if (rec_eol[3] !== 1'b1 || rec_eol[2] !== 1'b0 || rec_eol[7] !== 1'b1) begin fails++; $display("FAIL p16_eol got %0b%0b%0b exp 101", rec_eol[3], rec_eol[2], rec_eol[7]); end
            tests++; if (rec_cyc[0] != mark_cyc + 2) begin fails++; $display("FAIL p16_latency got %0d exp %0d", rec_cyc[0], mark_cyc + 2); end
        end
        tests++; if (line_err !== 1'b0) begin fails++; $display("FAIL p16_line_err got %0b exp 0", line_err); end
    endtask

    task automatic test_pack8();
        rec_clear();
        byte_mode = 1'b1;
        drive_vsync();
        byte_mode = 1'b0;   // mid-frame change must be ignored
        for (int l = 0; l < 4; l++) drive_line(l, 8);
        tests++; if (rec_data.size() != 8) begin fails++; $display("FAIL p8_count got %0d exp 8", rec_data.size()); end
        if (rec_data.size() == 8) begin
            tests++; if (rec_data[0] !== 16'h0012) begin fails++; $display("FAIL p8_line1 got %h exp 0012", rec_data[0]); end
            for (int i = 0; i < 4; i++) begin
                tests++; if (rec_data[4 + i] !== 16'(16'h0022 + i)) begin fails++; $display("FAIL p8_data%0d got %h exp %h", i, rec_data[4 + i], 16'(16'h0022 + i)); end
            end
            tests++; if (rec_eol[7] !== 1'b1 || rec_eol[3] !== 1'b1 || rec_eol[6] !== 1'b0) begin fails++; $display("FAIL p8_eol got %0b%0b%0b exp 110", rec_eol[7], rec_eol[3], rec_eol[6]); end
            tests++; if (rec_sof[0] !== 1'b1) begin fails++; $display("FAIL p8_sof got %0b exp 1", rec_sof[0]); end
        end
        tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL p8_frame_cnt got %0d exp 2", frame_cnt); end
    endtask

    task automatic test_line_err();
        byte_mode = 1'b0;
        drive_vsync();
        drive_line(0, 15);
        tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL err_set got %0b exp 1", line_err); end
        for (int l = 1; l < 4; l++) drive_line(l, 16);
        rec_clear();
        drive_frame(16);
        tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %0b exp 1", line_err); end
        tests++; if (rec_data.size() != 8) begin fails++; $display("FAIL err_continue got %0d exp 8", rec_data.size()); end
        tests++; if (frame_cnt !== 8'd4) begin fails++; $display("FAIL err_frame_cnt got %0d exp 4", frame_cnt); end
        en = 1'b0;
        @(negedge pclk);
        tests++; if (line_err !== 1'b0) begin fails++; $display("FAIL err_clear got %0b exp 0", line_err); end
        tests++; if (capturing !== 1'b0) begin fails++; $display("FAIL err_idle got %0b exp 0", capturing); end
        en = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_disable();
        drive_frame(16);
        drive_frame(16);
        drive_vsync();
        tests++; if (frame_cnt !== 8'd5 || capturing !== 1'b1) begin fails++; $display("FAIL dis_enter got cnt %0d cap %0b exp 5 1", frame_cnt, capturing); end
        rec_clear();
        drive_line(0, 16);
        for (int i = 0; i < 8; i++) begin
            href = 1'b1;
            din  = 8'(8'h10 + i);
            @(negedge pclk);
        end
        en  = 1'b0;
        din = 8'h18;
        @(negedge pclk);
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL dis_pix_valid got %0b exp 0", pix_valid); end
        tests++; if (capturing !== 1'b0) begin fails++; $display("FAIL dis_capturing got %0b exp 0", capturing); end
        href = 1'b0;
        repeat (3) @(negedge pclk);
        en = 1'b1;
        repeat (2) @(negedge pclk);
        tests++; if (rec_data.size() != 1 || rec_data[0] !== 16'h1415) begin fails++; $display("FAIL dis_partial got n=%0d first=%h exp n=1 1415", rec_data.size(), (rec_data.size() > 0) ? rec_data[0] : 16'h0); end
        drive_frame(16);
        drive_frame(16);
        tests++; if (capturing !== 1'b0 || rec_data.size() != 1) begin fails++; $display("FAIL dis_reskip got cap %0b n=%0d exp 0 1", capturing, rec_data.size()); end
        tests++; if (frame_cnt !== 8'd5) begin fails++; $display("FAIL dis_held got %0d exp 5", frame_cnt); end
        drive_vsync();
        tests++; if (frame_cnt !== 8'd6 || capturing !== 1'b1) begin fails++; $display("FAIL dis_resume got cnt %0d cap %0b exp 6 1", frame_cnt, capturing); end
        rec_clear();
        for (int l = 0; l < 4; l++) drive_line(l, 16);
        tests++; if (rec_data.size() != 8 || line_err !== 1'b0) begin fails++; $display("FAIL dis_frame got n=%0d err %0b exp 8 0", rec_data.size(), line_err); end
    endtask

    task automatic test_wrap_and_coincident();
        en   = 1'b0;
        en_b = 1'b1;
        repeat (2) @(negedge pclk);
        for (int f = 0; f < 255; f++) drive_vsync();
        tests++; if (frame_cnt_b !== 8'd255 || capturing_b !== 1'b1) begin fails++; $display("FAIL wrap_255 got cnt %0d cap %0b exp 255 1", frame_cnt_b, capturing_b); end
        tests++; if (frame_cnt !== 8'd6) begin fails++; $display("FAIL wrap_a_held got %0d exp 6", frame_cnt); end
        drive_vsync();
        tests++; if (frame_cnt_b !== 8'd0) begin fails++; $display("FAIL wrap_0 got %0d exp 0", frame_cnt_b); end
        for (int l = 0; l < 3; l++) drive_line(l, 16);
        for (int i = 0; i < 16; i++) begin
            href = 1'b1;
            din  = 8'(8'h30 + i);
            @(negedge pclk);
        end
        href  = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge pclk);
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
        tests++; if (line_err_b !== 1'b0) begin fails++; $display("FAIL coinc_line_err got %0b exp 0", line_err_b); end
        tests++; if (frame_cnt_b !== 8'd1) begin fails++; $display("FAIL coinc_frame_cnt got %0d exp 1", frame_cnt_b); end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        en_b      = 1'b0;
        vsync     = 1'b0;
        href      = 1'b0;
        din       = 8'h00;
        byte_mode = 1'b0;
        repeat (3) @(negedge pclk);
        test_reset();
        test_skip();
        test_pack16();
        test_pack8();
        test_line_err();
        test_disable();
        test_wrap_and_coincident();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_dvp_capture.md
Name: cam_dvp_capture

Overview:
- Parametrised DVP camera capture front end; next generation of the OV5640 pixel-capture path.
- Sits between the camera pins (pclk domain) and the frame-buffer write FIFO/SDRAM writer.
- Adds the following over the previous capture logic:
  - selectable 8/16-bit pixel packing;
  - configurable start-up frame skip;
  - window cropping;
  - SOF/EOL framing flags;
  - frame counter;
  - sticky line-length error detection.

Parameters:
- IN_W, 1024, active pixels per input line.
- IN_H, 768, active lines per input frame.
- WIN_X0, 0, first captured column (0..IN_W-1).
- WIN_Y0, 0, first captured line (0..IN_H-1).
- WIN_W, 1024, captured columns; WIN_X0+WIN_W <= IN_W.
- WIN_H, 768, captured lines; WIN_Y0+WIN_H <= IN_H.
- SKIP_FRAMES, 10, complete frames discarded after enable (0 allowed).

Ports:
- pclk  in  1  camera pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable (tie to sensor init_done & cfg_done).
- vsync  in  1  camera frame sync, active-high pulse between frames.
- href  in  1  camera line valid, active-high.
- din  in  8  camera data bus.
- byte_mode  in  1  0 = RGB565, 2 bytes/pixel; 1 = RAW8/Y8, 1 byte/pixel.
- pix_valid  out  1  pix_data valid this cycle.
- pix_data  out  16  pixel; 16-bit = {first byte, second byte}; 8-bit = {8'h00, byte}.
- sof  out  1  high with first windowed pixel of a frame.
- eol  out  1  high with last windowed pixel of each windowed line.
- frame_cnt  out  8  captured (ACTIVE) frames, wraps.
- line_err  out  1  sticky line-length error.
- capturing  out  1  high while in ACTIVE state.

Behaviour:

Reset and input staging:
- Reset: all outputs 0; state IDLE; all counters 0.
- vsync, href, din registered once on pclk (stage 1).
- Edges are detected from stage 1 vs stage 2.

State machine:
- IDLE: wait for en=1, then go to WAIT_VS.
- WAIT_VS: on vsync rising edge, load skip counter = SKIP_FRAMES. Go to ACTIVE if SKIP_FRAMES=0, else SKIP. Also latch byte_mode.
- SKIP: on each vsync rising edge, decrement the skip counter. When it reaches 0, go to ACTIVE and latch byte_mode.
- ACTIVE:
  - On each vsync rising edge: frame_cnt += 1 (255 -> 0); byte_mode re-latched; x and y cleared.
  - byte_mode changes mid-frame have no effect.
- en=0 in any state forces IDLE on the next cycle:
  - pix_valid, sof, eol, capturing go to 0 on that cycle;
  - partial line discarded; line_err cleared.
  - frame_cnt is held; it is cleared only by reset.

Packing (ACTIVE, stage-1 href=1, stage-1 vsync=0):
- Byte phase toggles each cycle; it is forced to phase 0 on href rising edge.
- 16-bit mode: phase 0 byte stored as high byte; pixel completes on phase 1.
- 8-bit mode: every byte completes a pixel.
- href high while vsync high is ignored.

Counters:
- x = completed pixels in the current line; cleared on href rising edge.
- y = line index; increments on href falling edge; cleared on vsync rising edge; saturates at IN_H.

Window and output:
- A completed pixel is in-window iff WIN_X0 <= x < WIN_X0+WIN_W and WIN_Y0 <= y < WIN_Y0+WIN_H, with x being the pre-increment value.
- Outputs registered: pix_valid/pix_data rise on the 2nd pclk edge after the completing byte is on din (latency 2).
- Only in-window pixels produce pix_valid.
- sof = pix_valid & x==WIN_X0 & y==WIN_Y0.
- eol = pix_valid & x==WIN_X0+WIN_W-1.
- pix_data holds its last value when pix_valid=0.

line_err (ACTIVE only):
- Set on href falling edge if pixel count != IN_W.
- Set on href falling edge in 16-bit mode if a high byte is pending (odd byte count).
- Set if y would exceed IN_H.
- Once set, remains 1 until en=0 or reset.
- Capture continues after an error.

Simultaneous events:
- href falling edge and vsync rising edge in the same cycle: line end is processed first (y increment, error check), then the frame clear.

Test Plan:
Bench uses IN_W=8, IN_H=4, WIN_X0=2, WIN_Y0=1, WIN_W=4, WIN_H=2, SKIP_FRAMES=2.
1. Reset then en=1, three vsync pulses, 16-bit frames with byte ramp 0x00.. -> no pix_valid in the first two frames; capturing=1 after the 3rd vsync rise; frame_cnt=1.
2. ACTIVE 16-bit frame, line 1 bytes 0x10..0x1F -> 4 pix_valid, pix_data 0x1415, 0x1617, 0x1819, 0x1A1B. sof with 0x1415. eol with 0x1A1B. Latency 2 cycles from the second byte.
3. byte_mode=1 latched at vsync, line 2 bytes 0x20..0x27 -> pix_data 0x0022..0x0025, eol with 0x0025. Lines 0 and 3 produce no pix_valid.
4. 16-bit line of 15 bytes -> line_err=1 after href falls and stays 1 over following good frames. en low one cycle -> line_err=0.
5. en dropped mid-line 1 -> pix_valid=0 next cycle, state IDLE. Re-enable -> SKIP_FRAMES frames skipped again; frame_cnt continues from its held value.
6. 256 ACTIVE frames with SKIP_FRAMES=0 -> frame_cnt wraps 255 -> 0. href fall and vsync rise in the same cycle -> no line_err for a correct 8-pixel line.
